adc_conv_scheduler: RTL and testbench

- Sequences conversions on the single SPI ADC conversion engine: on-demand requests from game logic plus a periodic background scan of every channel.
- Arbitrates round-robin between pending channels and issues one-shot start/channel commands to the engine.
- Holds the latest 12-bit result per channel and pulses a per-channel acknowledge when each result is stored.
- Detects a hung engine with a timeout.

---
 rtl/adc_conv_scheduler.sv | 142 ++++++++++++++
 tb/tb_adc_conv_scheduler.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_conv_scheduler.sv
// Conversion scheduler for the shared SPI ADC engine: round-robin arbitration of
// on-demand and periodic scan requests, per-channel result storage, hang watchdog.
module adc_conv_scheduler #(
    parameter int CH_W        = 1,
    parameter int SCAN_PERIOD = 50000,
    parameter int TIMEOUT     = 4095
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    scan_en,
    input  logic [(2**CH_W)-1:0]    req,
    output logic                    conv_start,
    output logic [CH_W-1:0]         conv_ch,
    input  logic                    conv_done,
    input  logic [11:0]             conv_data,
    output logic [12*(2**CH_W)-1:0] ch_result,
    output logic [(2**CH_W)-1:0]    ack,
    output logic                    busy,
    output logic                    timeout_err
);
    localparam int unsigned NUM_CH = 2 ** CH_W;
    localparam int SC_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [NUM_CH-1:0] pend;
    logic [CH_W-1:0]   last_ch;
    logic [SC_W-1:0]   scan_cnt;
    logic [WD_W-1:0]   wd_cnt;
    logic              scan_tick;
    logic              wd_expired;
    logic              grant_vld;
    logic [CH_W-1:0]   grant_ch;
    logic [CH_W-1:0]   cand;
    logic [NUM_CH-1:0] grant_mask;

    assign scan_tick  = scan_en && (scan_cnt == SC_W'(SCAN_PERIOD - 1));
    assign wd_expired = (wd_cnt == WD_W'(TIMEOUT - 1));

    // Round-robin search starting just after the last granted channel; the
    // index wraps naturally because NUM_CH is a power of two.
    always_comb begin
        grant_vld = 1'b0;
        grant_ch  = '0;
        cand      = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            cand = last_ch + CH_W'(i);
            if (!grant_vld && pend[cand]) begin
                grant_vld = 1'b1;
                grant_ch  = cand;
            end
        end
    end

    always_comb begin
        grant_mask = '0;
        if (state == IDLE && grant_vld) begin
            grant_mask[grant_ch] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant_vld) state_nxt = START;
            START:   state_nxt = WAIT;
            WAIT:    if (conv_done || wd_expired) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        conv_start = (state == START);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend        <= '0;
            last_ch     <= '1;
            scan_cnt    <= '0;
            wd_cnt      <= '0;
            conv_ch     <= '0;
            ch_result   <= '0;
            ack         <= '0;
            timeout_err <= 1'b0;
        end else begin
            ack <= '0;

            if (!scan_en || scan_tick) begin
                scan_cnt <= '0;
            end else begin
                scan_cnt <= scan_cnt + SC_W'(1);
            end

            // A new request in the grant cycle survives the clear.
            pend <= (pend & ~grant_mask) | req | {NUM_CH{scan_tick}};

            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        conv_ch <= grant_ch;
                        last_ch <= grant_ch;
                    end
                end
                START: begin
                    wd_cnt <= '0;
                end
                WAIT: begin
                    wd_cnt <= wd_cnt + WD_W'(1);
                    if (conv_done) begin
                        for (int unsigned n = 0; n < NUM_CH; n++) begin
                            if (conv_ch == CH_W'(n)) begin
                                ch_result[12*n +: 12] <= conv_data;
                                ack[n]                <= 1'b1;
                            end
                        end
                    end else if (wd_expired) begin
                        timeout_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_adc_conv_scheduler.sv
// Bench for adc_conv_scheduler: two instances with different watchdog limits,
// directed scenarios then random traffic, all checked against a cycle model.
module tb_adc_conv_scheduler;
    localparam int SP  = 100;
    localparam int TO0 = 64;
    localparam int TO1 = 16;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic        scan_en = 1'b0;
    logic [1:0]  req     = '0;
    logic        done [2] = '{1'b0, 1'b0};
    logic [11:0] data [2] = '{12'h000, 12'h000};
    logic        start [2];
    logic [0:0]  ch [2];
    logic [23:0] result [2];
    logic [1:0]  ack [2];
    logic        busy [2];
    logic        terr [2];

    adc_conv_scheduler #(.CH_W(1), .SCAN_PERIOD(SP), .TIMEOUT(TO0)) dut0 (
        .clk(clk), .rst(rst), .scan_en(scan_en), .req(req),
        .conv_start(start[0]), .conv_ch(ch[0]), .conv_done(done[0]), .conv_data(data[0]),
        .ch_result(result[0]), .ack(ack[0]), .busy(busy[0]), .timeout_err(terr[0])
    );

    adc_conv_scheduler #(.CH_W(1), .SCAN_PERIOD(SP), .TIMEOUT(TO1)) dut1 (
        .clk(clk), .rst(rst), .scan_en(scan_en), .req(req),
        .conv_start(start[1]), .conv_ch(ch[1]), .conv_done(done[1]), .conv_data(data[1]),
        .ch_result(result[1]), .ack(ack[1]), .busy(busy[1]), .timeout_err(terr[1])
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_err  = 0;
    bit chk_on = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // Reference model. age counts cycles since a grant: 0 = nothing in flight,
    // 1 = start cycle, 2.. = waiting for the engine (age-2 cycles already waited).
    int          tout [2] = '{TO0, TO1};
    bit [1:0]    m_pend [2];
    int          m_last [2];
    int          m_age [2];
    int          m_ch [2];
    int          m_scan [2];
    bit [11:0]   m_res [2][2];
    bit [1:0]    m_ack [2];
    bit          m_terr [2];

    task automatic model_step(input int i);
        bit       tick;
        bit [1:0] clr;
        int       c;
        if (rst) begin
            m_pend[i] = '0; m_last[i] = 1; m_age[i] = 0; m_ch[i] = 0; m_scan[i] = 0;
            m_res[i][0] = '0; m_res[i][1] = '0; m_ack[i] = '0; m_terr[i] = 1'b0;
            return;
        end
        tick      = scan_en && (m_scan[i] == SP - 1);
        m_scan[i] = scan_en ? (m_scan[i] + 1) % SP : 0;
        m_ack[i]  = '0;
        clr       = '0;
        if (m_age[i] == 0) begin
            for (int k = 1; k <= 2; k++) begin
                c = (m_last[i] + k) % 2;
                if (clr == 0 && m_pend[i][c]) begin
                    clr[c] = 1'b1; m_ch[i] = c; m_last[i] = c; m_age[i] = 1;
                end
            end
        end else if (m_age[i] == 1) begin
            m_age[i] = 2;
        end else if (done[i]) begin
            m_res[i][m_ch[i]] = data[i];
            m_ack[i][m_ch[i]] = 1'b1;
            m_age[i] = 0;
        end else if (m_age[i] - 1 == tout[i]) begin
            m_terr[i] = 1'b1;
            m_age[i]  = 0;
        end else begin
            m_age[i]++;
        end
        m_pend[i] = (m_pend[i] & ~clr) | req | (tick ? 2'b11 : 2'b00);
    endtask

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) model_step(i);
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < 2; i++) begin
                check($sformatf("d%0d.conv_start", i), 32'(start[i]), 32'(m_age[i] == 1));
                check($sformatf("d%0d.conv_ch", i), 32'(ch[i]), 32'(m_ch[i]));
                check($sformatf("d%0d.busy", i), 32'(busy[i]), 32'(m_age[i] != 0));
                check($sformatf("d%0d.ack", i), 32'(ack[i]), 32'(m_ack[i]));
                check($sformatf("d%0d.ch_result", i), 32'(result[i]), 32'({m_res[i][1], m_res[i][0]}));
                check($sformatf("d%0d.timeout_err", i), 32'(terr[i]), 32'(m_terr[i]));
            end
        end
    end

    // Engine stand-in: answers each start after a latency (mode 0 never answers,
    // 1 fixed e_lat, 2 random), optionally with stray done pulses.
    int          e_cnt [2] = '{0, 0};
    bit [11:0]   e_dat [2];
    int          e_mode = 1;
    int          e_lat = 5;
    bit          e_rand_data = 1'b0;
    logic [11:0] e_val [2] = '{12'h111, 12'h222};
    int          noise_div = 2;

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            done[i] = 1'b0;
            if (start[i] === 1'b1) begin
                e_dat[i] = e_rand_data ? 12'($urandom) : e_val[ch[i]];
                e_cnt[i] = (e_mode == 0) ? 0 : (e_mode == 1) ? e_lat : int'($urandom_range(1, 24));
            end else if (e_cnt[i] > 0) begin
                e_cnt[i]--;
                if (e_cnt[i] == 0) begin
                    done[i] = 1'b1;
                    data[i] = e_dat[i];
                end
            end
            if (noise_div > 0 && $urandom_range(0, noise_div - 1) == 0) begin
                done[i] = 1'b1;
                data[i] = 12'($urandom);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req(input logic [1:0] r);
        req = r;
        @(negedge clk);
        req = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    task automatic wait_ack(input int i, input int lim, output bit seen);
        seen = 1'b0;
        for (int k = 0; k < lim && !seen; k++) begin
            @(negedge clk);
            if (ack[i] != 2'b00) seen = 1'b1;
        end
    endtask

    initial begin
        bit seen;
        bit any_ack;
        int n_st;
        int first;

        // Reset with requests and done toggling.
        @(negedge clk);
        chk_on = 1'b1;
        for (int k = 0; k < 3; k++) begin
            req = 2'($urandom);
            @(negedge clk);
        end
        req = '0; rst = 1'b0; noise_div = 0;
        cyc(10);
        check("rst.start", 32'(start[0]), 32'd0);
        check("rst.busy", 32'(busy[0]), 32'd0);
        check("rst.result", 32'(result[0]), 32'd0);

        // Single request on ch1, engine answers 20 cycles after start.
        e_mode = 1; e_lat = 20; e_val[1] = 12'hABC;
        pulse_req(2'b10);
        @(negedge clk);
        check("single.start_at_2", 32'(start[0]), 32'd1);
        check("single.ch", 32'(ch[0]), 32'd1);
        wait_ack(0, 40, seen);
        check("single.ack_seen", 32'(seen), 32'd1);
        check("single.ack", 32'(ack[0]), 32'h2);
        check("single.hi", 32'(result[0][23:12]), 32'hABC);
        check("single.lo", 32'(result[0][11:0]), 32'h0);
        @(negedge clk);
        check("single.ack_one_cycle", 32'(ack[0]), 32'h0);
        cyc(20);

        // Simultaneous requests: ch0 then ch1.
        e_lat = 6; e_val[0] = 12'h111; e_val[1] = 12'h222;
        pulse_req(2'b11);
        wait_ack(0, 40, seen);
        check("simul.first_ack", 32'(ack[0]), 32'h1);
        check("simul.ch0", 32'(result[0][11:0]), 32'h111);
        wait_ack(0, 40, seen);
        check("simul.second_ack", 32'(ack[0]), 32'h2);
        check("simul.ch1", 32'(result[0][23:12]), 32'h222);
        cyc(10);

        // Timeout: good ch0 conversion, then a silent engine for ch1.
        do_reset();
        pulse_req(2'b01);
        cyc(20);
        e_mode = 0;
        pulse_req(2'b10);
        cyc(17);
        check("to.busy_last_wait", 32'(busy[1]), 32'd1);
        check("to.terr_before", 32'(terr[1]), 32'd0);
        cyc(1);
        check("to.idle_after", 32'(busy[1]), 32'd0);
        check("to.terr_set", 32'(terr[1]), 32'd1);
        check("to.result_kept", 32'(result[1]), 32'h111);
        cyc(60);
        e_mode = 1; e_val[1] = 12'h5A5;
        pulse_req(2'b10);
        wait_ack(1, 40, seen);
        check("to.recover_ack", 32'(ack[1]), 32'h2);
        check("to.recover_data", 32'(result[1][23:12]), 32'h5A5);
        check("to.terr_sticky", 32'(terr[1]), 32'd1);
        cyc(5);

        // Re-request of ch0 while it is converting.
        e_lat = 10;
        n_st = 0;
        req = 2'b01;
        @(negedge clk);
        req = '0;
        for (int k = 2; k <= 60; k++) begin
            @(negedge clk);
            if (start[0]) n_st++;
            req = (k == 5) ? 2'b01 : 2'b00;
        end
        check("rereq.starts", 32'(n_st), 32'd2);

        // Reset during WAIT, engine answers afterwards.
        e_lat = 30;
        pulse_req(2'b01);
        cyc(8);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        any_ack = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack[0] != 2'b00) any_ack = 1'b1;
        end
        check("midrst.no_ack", 32'(any_ack), 32'd0);
        check("midrst.result", 32'(result[0]), 32'd0);

        // Background scan.
        e_lat = 5;
        scan_en = 1'b1;
        first = 0;
        for (int n = 1; n <= 150 && first == 0; n++) begin
            @(negedge clk);
            if (start[0]) first = n;
        end
        check("scan.first_start", 32'(first), 32'd101);
        n_st = 0;
        for (int k = 0; k < 149; k++) begin
            @(negedge clk);
            if (start[0]) n_st++;
        end
        check("scan.starts", 32'(n_st), 32'd3);
        scan_en = 1'b0;
        cyc(30);
        n_st = 0;
        for (int k = 0; k < 250; k++) begin
            @(negedge clk);
            if (start[0]) n_st++;
        end
        check("scan.off_no_start", 32'(n_st), 32'd0);

        // Random traffic.
        e_mode = 2; e_rand_data = 1'b1; noise_div = 40;
        for (int k = 0; k < 4000; k++) begin
            req = ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00;
            if ($urandom_range(0, 299) == 0) scan_en = ~scan_en;
            rst = ($urandom_range(0, 999) == 0);
            @(negedge clk);
        end
        req = '0; rst = 1'b0;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
